// File: rtl/dmem_mmio_bus.sv
// Data-side memory system: word-addressed RAM plus an MMIO window with GPIO,
// a free-running timer with sticky compare flag, and a FIFO-buffered 8N1 UART.
module dmem_mmio_bus #(
    parameter int unsigned RAM_WORDS  = 1024,
    parameter int unsigned BAUD_DIV   = 868,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] i_data_mem_addr,
    input  logic [31:0] i_data_mem_write_data,
    input  logic        i_data_mem_read_en,
    input  logic        i_data_mem_write_en,
    output logic [31:0] o_data_mem_read_data,
    output logic [15:0] o_gpio,
    output logic        o_uart_tx,
    output logic        o_timer_irq
);

    localparam int unsigned RAM_AW  = $clog2(RAM_WORDS);
    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W   = FIFO_AW + 1;
    localparam int unsigned BAUD_W  = $clog2(BAUD_DIV);

    localparam logic [29:0] WA_GPIO = 30'h0400_0000;
    localparam logic [29:0] WA_UART = 30'h0400_0001;
    localparam logic [29:0] WA_CNT  = 30'h0400_0002;
    localparam logic [29:0] WA_CMP  = 30'h0400_0003;
    localparam logic [29:0] WA_IRQ  = 30'h0400_0004;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    logic [29:0]       word_addr;
    logic              ram_sel;
    logic [RAM_AW-1:0] ram_idx;
    logic              wr_ram, wr_gpio, wr_uart, wr_cnt, wr_cmp, wr_irq;
    logic              unused_addr_bits;

    logic [31:0]       mem_q [RAM_WORDS];
    logic [15:0]       gpio_q, gpio_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       cmp_q, cmp_d;
    logic              irq_q, irq_d;

    logic [7:0]         fifo_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               full_c, empty_c, busy_c, push_c, pop_c;

    uart_state_e       state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              baud_end_c;

    // Address decode; byte offset bits carry no meaning on a word-only bus
    assign word_addr        = i_data_mem_addr[31:2];
    assign unused_addr_bits = ^i_data_mem_addr[1:0];
    assign ram_sel          = (word_addr[29:RAM_AW] == '0);
    assign ram_idx          = word_addr[RAM_AW-1:0];

    assign wr_ram  = i_data_mem_write_en && ram_sel;
    assign wr_gpio = i_data_mem_write_en && (word_addr == WA_GPIO);
    assign wr_uart = i_data_mem_write_en && (word_addr == WA_UART);
    assign wr_cnt  = i_data_mem_write_en && (word_addr == WA_CNT);
    assign wr_cmp  = i_data_mem_write_en && (word_addr == WA_CMP);
    assign wr_irq  = i_data_mem_write_en && (word_addr == WA_IRQ);

    assign full_c  = (occ_q == OCC_W'(FIFO_DEPTH));
    assign empty_c = (occ_q == '0);
    assign busy_c  = (state_q != ST_IDLE) || !empty_c;
    assign push_c  = wr_uart && !full_c;

    // Combinational read mux; returns pre-write state on a same-cycle store
    always_comb begin
        o_data_mem_read_data = '0;
        if (i_data_mem_read_en) begin
            if (ram_sel) begin
                o_data_mem_read_data = mem_q[ram_idx];
            end else begin
                case (word_addr)
                    WA_GPIO: o_data_mem_read_data = {16'h0000, gpio_q};
                    WA_UART: o_data_mem_read_data = {30'h0, busy_c, full_c};
                    WA_CNT:  o_data_mem_read_data = cnt_q;
                    WA_CMP:  o_data_mem_read_data = cmp_q;
                    WA_IRQ:  o_data_mem_read_data = {31'h0, irq_q};
                    default: o_data_mem_read_data = '0;
                endcase
            end
        end
    end

    // GPIO, timer and compare flag; a match beats a coincident clear
    always_comb begin
        gpio_d = gpio_q;
        cmp_d  = cmp_q;
        irq_d  = irq_q;
        cnt_d  = wr_cnt ? 32'h0 : cnt_q + 32'd1;
        if (wr_gpio) gpio_d = i_data_mem_write_data[15:0];
        if (wr_cmp)  cmp_d  = i_data_mem_write_data;
        if (cnt_q == cmp_q) begin
            irq_d = 1'b1;
        end else if (wr_irq && i_data_mem_write_data[0]) begin
            irq_d = 1'b0;
        end
    end

    // UART next-state; tx is registered from the next state so it changes with the state
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        pop_c      = 1'b0;
        tx_d       = 1'b1;
        baud_end_c = (baud_q == BAUD_W'(BAUD_DIV - 1));

        case (state_q)
            ST_IDLE: begin
                if (!empty_c) begin
                    state_d = ST_START;
                    pop_c   = 1'b1;
                    baud_d  = '0;
                end
            end
            ST_START: begin
                if (baud_end_c) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end_c) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (baud_end_c) begin
                    baud_d = '0;
                    if (!empty_c) begin
                        state_d = ST_START;
                        pop_c   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (pop_c) shreg_d = fifo_q[rd_ptr_q];

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[bit_d];
            default:  tx_d = 1'b1;
        endcase
    end

    // FIFO pointer and occupancy bookkeeping
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        if (push_c) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        if (pop_c)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        case ({push_c, pop_c})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            gpio_q   <= '0;
            cnt_q    <= '0;
            cmp_q    <= 32'hFFFF_FFFF;
            irq_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            gpio_q   <= gpio_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            irq_q    <= irq_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
        end
    end

    // Storage arrays are not reset
    always_ff @(posedge clk) begin
        if (wr_ram) mem_q[ram_idx] <= i_data_mem_write_data;
        if (push_c) fifo_q[wr_ptr_q] <= i_data_mem_write_data[7:0];
    end

    assign o_gpio      = gpio_q;
    assign o_uart_tx   = tx_q;
    assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_dmem_mmio_bus.sv
// Bench for dmem_mmio_bus: directed scenarios plus random traffic, checked cycle by
// cycle against a transaction-level model (byte queue + frame timeline for the UART).
module tb_dmem_mmio_bus;

    localparam int unsigned RAM_WORDS  = 256;
    localparam int unsigned BAUD_DIV   = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          FRAME      = 10 * BAUD_DIV;

    localparam logic [31:0] A_GPIO = 32'h1000_0000;
    localparam logic [31:0] A_UART = 32'h1000_0004;
    localparam logic [31:0] A_CNT  = 32'h1000_0008;
    localparam logic [31:0] A_CMP  = 32'h1000_000C;
    localparam logic [31:0] A_IRQ  = 32'h1000_0010;

    logic        clk;
    logic        rstn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        re;
    logic        we;
    logic [31:0] rdata;
    logic [15:0] gpio;
    logic        tx;
    logic        irq;

    dmem_mmio_bus #(
        .RAM_WORDS (RAM_WORDS),
        .BAUD_DIV  (BAUD_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .i_data_mem_addr      (addr),
        .i_data_mem_write_data(wdata),
        .i_data_mem_read_en   (re),
        .i_data_mem_write_en  (we),
        .o_data_mem_read_data (rdata),
        .o_gpio               (gpio),
        .o_uart_tx            (tx),
        .o_timer_irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: values visible during the upcoming cycle
    logic [31:0] m_mem [RAM_WORDS];
    bit          m_valid [RAM_WORDS];
    logic [15:0] m_gpio;
    logic [31:0] m_cnt;
    logic [31:0] m_cmp;
    logic        m_irq;
    logic [7:0]  m_q [$];
    bit          m_active;
    logic [7:0]  m_byte;
    int          m_elapsed;
    bit          m_init;

    int          n_checks;
    int          n_errors;
    logic [31:0] obs_rdata;
    logic        obs_tx;
    logic        obs_irq;
    logic [15:0] obs_gpio;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_tx();
        int idx;
        if (!m_active) return 1'b1;
        idx = m_elapsed / BAUD_DIV;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_byte[idx-1];
        return 1'b1;
    endfunction

    function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        v  = 32'h0;
        if (wa < 32'(RAM_WORDS * 4)) begin
            v = m_mem[wa >> 2];
            return m_valid[wa >> 2];
        end
        case (wa)
            A_GPIO: v = {16'h0, m_gpio};
            A_UART: v = {30'h0, (m_active || m_q.size() != 0),
                         (m_q.size() == FIFO_DEPTH)};
            A_CNT:  v = m_cnt;
            A_CMP:  v = m_cmp;
            A_IRQ:  v = {31'h0, m_irq};
            default: v = 32'h0;
        endcase
        return 1'b1;
    endfunction

    task automatic model_edge(input logic r_n, input logic [31:0] a, input logic [31:0] wd,
                              input logic w);
        logic [31:0] wa;
        bit          full_pre;
        if (!r_n) begin
            m_gpio = 16'h0; m_cnt = 32'h0; m_cmp = 32'hFFFF_FFFF; m_irq = 1'b0;
            m_q.delete(); m_active = 1'b0; m_elapsed = 0; m_init = 1'b1;
            return;
        end
        wa       = {a[31:2], 2'b00};
        full_pre = (m_q.size() == FIFO_DEPTH);
        if (m_cnt == m_cmp) m_irq = 1'b1;
        else if (w && wa == A_IRQ && wd[0]) m_irq = 1'b0;
        m_cnt = (w && wa == A_CNT) ? 32'h0 : m_cnt + 32'd1;
        if (w && wa == A_CMP)  m_cmp  = wd;
        if (w && wa == A_GPIO) m_gpio = wd[15:0];
        if (w && wa < 32'(RAM_WORDS * 4)) begin
            m_mem[wa >> 2]   = wd;
            m_valid[wa >> 2] = 1'b1;
        end
        if (!m_active) begin
            if (m_q.size() > 0) begin
                m_byte = m_q.pop_front(); m_active = 1'b1; m_elapsed = 0;
            end
        end else begin
            m_elapsed++;
            if (m_elapsed == FRAME) begin
                if (m_q.size() > 0) begin
                    m_byte = m_q.pop_front(); m_elapsed = 0;
                end else begin
                    m_active = 1'b0;
                end
            end
        end
        if (w && wa == A_UART && !full_pre) m_q.push_back(wd[7:0]);
    endtask

    // One bus cycle: drive, sample at negedge, compare against model, then advance model
    task automatic step(input logic r_n, input logic [31:0] a, input logic [31:0] wd,
                        input logic r, input logic w);
        logic [31:0] v;
        bit          known;
        rstn = r_n; addr = a; wdata = wd; re = r; we = w;
        @(negedge clk);
        obs_rdata = rdata; obs_tx = tx; obs_irq = irq; obs_gpio = gpio;
        if (m_init) begin
            check("tx", 32'(tx), 32'(m_tx()));
            check("gpio", 32'(gpio), 32'(m_gpio));
            check("irq", 32'(irq), 32'(m_irq));
            known = m_read(a, v);
            if (!r) begin
                known = 1'b1; v = 32'h0;
            end
            if (known) check("rdata", rdata, v);
        end
        @(posedge clk);
        model_edge(r_n, a, wd, w);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, A_UART, 32'h0, 1'b1, 1'b0);
    endtask

    logic [7:0]  pat;
    logic        exp_bit;
    int          bi;
    int          n_busy;
    bit          found;
    int          r;
    logic [31:0] ra;
    logic [31:0] rw;
    logic [31:0] unm [5];

    initial begin
        n_checks = 0; n_errors = 0; m_init = 1'b0;
        m_active = 1'b0; m_elapsed = 0; m_byte = 8'h0;
        for (int i = 0; i < RAM_WORDS; i++) m_valid[i] = 1'b0;
        rstn = 1'b0; addr = 32'h0; wdata = 32'h0; re = 1'b0; we = 1'b0;
        @(posedge clk); #1;

        // Reset and idle values
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step(1'b1, A_CMP, 32'h0, 1'b1, 1'b0);
        check("rst_cmp", obs_rdata, 32'hFFFF_FFFF);
        check("rst_gpio", 32'(obs_gpio), 32'h0);
        check("rst_tx", 32'(obs_tx), 32'h1);
        check("rst_irq", 32'(obs_irq), 32'h0);
        step(1'b1, A_UART, 32'h0, 1'b1, 1'b0);
        check("rst_uart", obs_rdata, 32'h0);

        // RAM access, offset bits, unmapped and read_en low
        step(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0010, 32'h0, 1'b1, 1'b0);
        check("ram_rd", obs_rdata, 32'hDEAD_BEEF);
        step(1'b1, 32'h0000_0013, 32'h0, 1'b1, 1'b0);
        check("ram_rd_off", obs_rdata, 32'hDEAD_BEEF);
        step(1'b1, 32'h2000_0000, 32'h0, 1'b1, 1'b0);
        check("unmapped_rd", obs_rdata, 32'h0);
        step(1'b1, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
        check("re_low", obs_rdata, 32'h0);

        // Read and write in the same cycle
        step(1'b1, 32'h0000_0020, 32'h1, 1'b0, 1'b1);
        step(1'b1, 32'h0000_0020, 32'h2, 1'b1, 1'b1);
        check("rw_old", obs_rdata, 32'h1);
        step(1'b1, 32'h0000_0020, 32'h0, 1'b1, 1'b0);
        check("rw_new", obs_rdata, 32'h2);

        // Timer compare: clear, cmp=20, irq appears after the count==20 edge
        step(1'b1, A_CNT, 32'h0, 1'b0, 1'b1);
        step(1'b1, A_CMP, 32'd20, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, A_CNT, 32'h0, 1'b1, 1'b0);
            check("irq_pre", 32'(obs_irq), 32'h0);
        end
        step(1'b1, A_CNT, 32'h0, 1'b1, 1'b0);
        check("irq_rise", 32'(obs_irq), 32'h1);
        check("cnt_at_rise", obs_rdata, 32'd21);
        step(1'b1, A_IRQ, 32'h1, 1'b0, 1'b1);
        step(1'b1, A_IRQ, 32'h0, 1'b1, 1'b0);
        check("irq_w1c", obs_rdata, 32'h0);

        // W1C coinciding with a match: set wins
        step(1'b1, A_CMP, m_cnt + 32'd6, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_cnt == m_cmp) found = 1'b1;
            else step(1'b1, A_CNT, 32'h0, 1'b1, 1'b0);
        end
        check("irq_sync_found", 32'(found), 32'h1);
        step(1'b1, A_IRQ, 32'h1, 1'b0, 1'b1);
        step(1'b1, A_IRQ, 32'h0, 1'b1, 1'b0);
        check("irq_set_wins", 32'(obs_irq), 32'h1);
        step(1'b1, A_IRQ, 32'h1, 1'b0, 1'b1);
        step(1'b1, A_IRQ, 32'h0, 1'b1, 1'b0);
        check("irq_clear", 32'(obs_irq), 32'h0);

        // Single frame 0xA5
        pat = 8'hA5;
        step(1'b1, A_UART, {24'h0, pat}, 1'b0, 1'b1);
        step(1'b1, A_UART, 32'h0, 1'b1, 1'b0);
        check("uart_pre", 32'(obs_tx), 32'h1);
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, A_UART, 32'h0, 1'b1, 1'b0);
            bi = i / BAUD_DIV;
            exp_bit = (bi == 0) ? 1'b0 : (bi <= 8) ? pat[bi-1] : 1'b1;
            check("uart_a5", 32'(obs_tx), 32'(exp_bit));
        end
        step(1'b1, A_UART, 32'h0, 1'b1, 1'b0);
        check("uart_a5_idle", obs_rdata, 32'h0);

        // Six back-to-back pushes: one popped, four buffered, one dropped
        for (int i = 0; i < 6; i++) step(1'b1, A_UART, 32'($urandom_range(0, 255)), 1'b0, 1'b1);
        step(1'b1, A_UART, 32'h0, 1'b1, 1'b0);
        check("fifo_full", obs_rdata, 32'h3);
        n_busy = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'b1, A_UART, 32'h0, 1'b1, 1'b0);
            if (obs_rdata[1] == 1'b0) break;
            n_busy++;
        end
        check("fifo_busy_len", 32'(n_busy), 32'(5 * FRAME - 5));

        // Reset mid-frame
        step(1'b1, A_UART, 32'h11, 1'b0, 1'b1);
        step(1'b1, A_UART, 32'h22, 1'b0, 1'b1);
        idle(17);
        step(1'b0, A_UART, 32'h0, 1'b0, 1'b0);
        step(1'b1, A_UART, 32'h0, 1'b1, 1'b0);
        check("rst_mid_tx", 32'(obs_tx), 32'h1);
        check("rst_mid_busy", obs_rdata, 32'h0);

        // Random traffic
        unm[0] = 32'h2000_0000; unm[1] = 32'h1000_0014; unm[2] = 32'h1000_0100;
        unm[3] = 32'(RAM_WORDS * 4); unm[4] = 32'hFFFF_FFFC;
        for (int n = 0; n < 3000; n++) begin
            r  = int'($urandom_range(0, 99));
            rw = $urandom;
            if (r < 30)      ra = 32'($urandom_range(0, 15)) << 2;
            else if (r < 40) ra = A_GPIO;
            else if (r < 52) ra = A_UART;
            else if (r < 58) ra = A_CNT;
            else if (r < 68) begin
                ra = A_CMP; rw = m_cnt + 32'($urandom_range(0, 40));
            end
            else if (r < 78) ra = A_IRQ;
            else             ra = unm[$urandom_range(0, 4)];
            ra = ra | 32'($urandom_range(0, 3));
            if (r == 99) step(1'b0, ra, rw, 1'($urandom), 1'b0);
            else step(1'b1, ra, rw, 1'($urandom), ($urandom_range(0, 2) == 0));
        end
        idle(5 * FRAME);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
